// File: rtl/main_mem_line_server_pkg.sv
// Shared types and constants for the line-granular backing-memory responder.
package main_mem_line_server_pkg;

  localparam int unsigned DEF_LINE_ADDR_LEN = 3;
  localparam int unsigned DEF_MEM_ADDR_LEN  = 12;
  localparam int unsigned DEF_LATENCY       = 8;
  localparam int unsigned WORD_W            = 32;
  localparam int unsigned LINE_WORDS        = 1 << DEF_LINE_ADDR_LEN;
  localparam int unsigned LAT_W             = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_BEAT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Bit offset of word idx inside a packed line.
  function automatic int unsigned word_lsb(input int unsigned idx);
    return idx * WORD_W;
  endfunction

endpackage

// File: rtl/main_mem_line_server_ram.sv
// Single-port word RAM, synchronous read, one word written per cycle.
module mem_word_ram #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
    r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/main_mem_line_server.sv
// Whole-line refill/writeback responder: fixed initial latency, then one word
// per cycle between the line buffers and the word RAM, with req/gnt handshake.
module main_mem_line_server
  import main_mem_line_server_pkg::*;
#(
  parameter  int unsigned LINE_ADDR_LEN = DEF_LINE_ADDR_LEN,
  parameter  int unsigned MEM_ADDR_LEN  = DEF_MEM_ADDR_LEN,
  parameter  int unsigned LATENCY       = DEF_LATENCY,
  localparam int unsigned LADDR_W       = MEM_ADDR_LEN - LINE_ADDR_LEN,
  localparam int unsigned LINE_W        = WORD_W << LINE_ADDR_LEN
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_mem_req,
  input  logic               i_mem_wr,
  input  logic [LADDR_W-1:0] i_mem_addr,
  input  logic [LINE_W-1:0]  i_mem_wr_line,
  output logic [LINE_W-1:0]  o_mem_rd_line,
  output logic               o_mem_gnt,
  output logic               o_busy,
  output logic [31:0]        o_rd_cnt,
  output logic [31:0]        o_wr_cnt
);

  state_t                   r_state, w_state_nxt;
  logic [LAT_W-1:0]         r_lat;
  logic [LINE_ADDR_LEN-1:0] r_beat, r_rd_idx;
  logic                     r_drain, r_wr, r_rd_vld, r_gnt, r_busy;
  logic [LADDR_W-1:0]       r_addr;
  logic [LINE_W-1:0]        r_wline, r_rd_line;
  logic [31:0]              r_rd_cnt, r_wr_cnt;

  logic                     w_accept, w_last_beat, w_ram_we;
  logic [MEM_ADDR_LEN-1:0]  w_ram_addr;
  logic [WORD_W-1:0]        w_ram_wdata, w_ram_rdata;

  assign w_accept    = (r_state == ST_IDLE) && i_mem_req && !r_gnt;
  assign w_last_beat = &r_beat;

  // Next-state logic; reads spend one extra BEAT cycle draining the RAM pipe.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = ST_WAIT;
      ST_WAIT: if (r_lat == '0) w_state_nxt = ST_BEAT;
      ST_BEAT: if (r_wr ? w_last_beat : r_drain) w_state_nxt = ST_DONE;
      ST_DONE: if (r_gnt && !i_mem_req) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lat     <= '0;
      r_beat    <= '0;
      r_rd_idx  <= '0;
      r_drain   <= 1'b0;
      r_wr      <= 1'b0;
      r_rd_vld  <= 1'b0;
      r_gnt     <= 1'b0;
      r_busy    <= 1'b0;
      r_addr    <= '0;
      r_wline   <= '0;
      r_rd_line <= '0;
      r_rd_cnt  <= '0;
      r_wr_cnt  <= '0;
    end else begin
      r_busy   <= (w_state_nxt != ST_IDLE);
      r_rd_vld <= (r_state == ST_BEAT) && !r_wr && !r_drain;
      r_rd_idx <= r_beat;
      if (r_rd_vld) r_rd_line[word_lsb(32'(r_rd_idx)) +: WORD_W] <= w_ram_rdata;

      case (r_state)
        ST_IDLE: if (w_accept) begin
          r_wr   <= i_mem_wr;
          r_addr <= i_mem_addr;
          r_lat  <= LAT_W'(LATENCY - 1);
          if (i_mem_wr) r_wline <= i_mem_wr_line;
        end
        ST_WAIT: begin
          if (r_lat == '0) begin
            r_beat  <= '0;
            r_drain <= 1'b0;
          end else begin
            r_lat <= r_lat - LAT_W'(1);
          end
        end
        ST_BEAT: begin
          r_beat <= r_beat + LINE_ADDR_LEN'(1);
          if (!r_wr && w_last_beat) r_drain <= 1'b1;
        end
        default: ;
      endcase

      // gnt rises one cycle into DONE; counters bump on that same first cycle.
      if (r_state == ST_DONE) begin
        r_gnt <= !(r_gnt && !i_mem_req);
        if (!r_gnt) begin
          if (r_wr) r_wr_cnt <= r_wr_cnt + 32'd1;
          else      r_rd_cnt <= r_rd_cnt + 32'd1;
        end
      end else begin
        r_gnt <= 1'b0;
      end
    end
  end

  // Reset blocks the in-flight write beat so an aborted line keeps only committed words.
  assign w_ram_we    = (r_state == ST_BEAT) && r_wr && !rst;
  assign w_ram_addr  = {r_addr, r_beat};
  assign w_ram_wdata = r_wline[word_lsb(32'(r_beat)) +: WORD_W];

  mem_word_ram #(
    .ADDR_W (MEM_ADDR_LEN),
    .DATA_W (WORD_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_addr  (w_ram_addr),
    .i_wdata (w_ram_wdata),
    .o_rdata (w_ram_rdata)
  );

  assign o_mem_rd_line = r_rd_line;
  assign o_mem_gnt     = r_gnt;
  assign o_busy        = r_busy;
  assign o_rd_cnt      = r_rd_cnt;
  assign o_wr_cnt      = r_wr_cnt;

endmodule

// File: tb/tb_main_mem_line_server.sv
// Bench for main_mem_line_server: default build plus a LATENCY=1 build,
// checked against a line-level memory/counter model and literal expectations.
module tb_main_mem_line_server;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0, req1, wr_i;
  logic [8:0]   addr_i;
  logic [255:0] wline_i;

  logic [255:0] rdl0, rdl1;
  logic         gnt0, gnt1, busy0, busy1;
  logic [31:0]  rdc0, rdc1, wrc0, wrc1;

  always #5 clk = ~clk;

  main_mem_line_server u_dut (
    .clk(clk), .rst(rst), .i_mem_req(req0), .i_mem_wr(wr_i), .i_mem_addr(addr_i),
    .i_mem_wr_line(wline_i), .o_mem_rd_line(rdl0), .o_mem_gnt(gnt0), .o_busy(busy0),
    .o_rd_cnt(rdc0), .o_wr_cnt(wrc0)
  );

  main_mem_line_server #(.LATENCY(1)) u_dut_l1 (
    .clk(clk), .rst(rst), .i_mem_req(req1), .i_mem_wr(wr_i), .i_mem_addr(addr_i),
    .i_mem_wr_line(wline_i), .o_mem_rd_line(rdl1), .o_mem_gnt(gnt1), .o_busy(busy1),
    .o_rd_cnt(rdc1), .o_wr_cnt(wrc1)
  );

  logic         gnt_v [2];
  logic         busy_v [2];
  logic [31:0]  rdc_v [2];
  logic [31:0]  wrc_v [2];
  logic [255:0] rdl_v [2];
  assign gnt_v[0] = gnt0;  assign gnt_v[1] = gnt1;
  assign busy_v[0] = busy0; assign busy_v[1] = busy1;
  assign rdc_v[0] = rdc0;  assign rdc_v[1] = rdc1;
  assign wrc_v[0] = wrc0;  assign wrc_v[1] = wrc1;
  assign rdl_v[0] = rdl0;  assign rdl_v[1] = rdl1;

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;
  int acc_cyc, fall_cyc;

  logic [31:0] mem_model [2][4096];
  int          exp_rd [2];
  int          exp_wr [2];
  bit          prev_gnt [2];
  bit          cur_wr [2];
  logic [8:0]  cur_addr [2];
  bit          rst_q = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [255:0] pat(input logic [31:0] base);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[32*i +: 32] = base + 32'(i);
    return l;
  endfunction

  function automatic logic [255:0] model_line(input int w, input logic [8:0] a);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[32*i +: 32] = mem_model[w][{a, 3'(i)}];
    return l;
  endfunction

  // Per-cycle compare: counters step once per gnt rising, read line matches memory model.
  always @(negedge clk) begin
    for (int w = 0; w < 2; w++) begin
      if (rst_q) begin
        exp_rd[w] = 0;
        exp_wr[w] = 0;
        check($sformatf("rst_gnt[%0d]", w),  256'(gnt_v[w]), 256'(0));
        check($sformatf("rst_busy[%0d]", w), 256'(busy_v[w]), 256'(0));
        check($sformatf("rst_rdcnt[%0d]", w), 256'(rdc_v[w]), 256'(0));
        check($sformatf("rst_wrcnt[%0d]", w), 256'(wrc_v[w]), 256'(0));
      end else begin
        if (gnt_v[w] && !prev_gnt[w]) begin
          if (cur_wr[w]) exp_wr[w]++;
          else           exp_rd[w]++;
        end
        check($sformatf("rd_cnt[%0d]", w), 256'(rdc_v[w]), 256'(exp_rd[w]));
        check($sformatf("wr_cnt[%0d]", w), 256'(wrc_v[w]), 256'(exp_wr[w]));
        if (gnt_v[w] && !cur_wr[w])
          check($sformatf("rd_line[%0d]", w), rdl_v[w], model_line(w, cur_addr[w]));
      end
      prev_gnt[w] = gnt_v[w];
    end
    rst_q = rst;
  end

  task automatic set_req(input int w, input logic v);
    if (w == 0) req0 = v;
    else        req1 = v;
  endtask

  // One full four-phase transaction; exp_lat counts cycles from accept to gnt.
  task automatic txn(input int w, input bit wr, input logic [8:0] addr, input logic [255:0] line,
                     input int exp_lat, input int hold, input bit b2b);
    int c;
    if (!b2b) @(posedge clk);
    #1;
    cur_wr[w]   = wr;
    cur_addr[w] = addr;
    if (wr) for (int i = 0; i < 8; i++) mem_model[w][{addr, 3'(i)}] = line[32*i +: 32];
    wr_i = wr; addr_i = addr; wline_i = line;
    set_req(w, 1'b1);
    c = 0;
    do begin @(negedge clk); c++; end while (!busy_v[w] && c < 50);
    check($sformatf("accept[%0d]", w), 256'(busy_v[w]), 256'(1));
    acc_cyc = cyc;
    wr_i = ~wr; addr_i = ~addr; wline_i = ~line;
    c = 0;
    while (!gnt_v[w] && c < 400) begin @(negedge clk); c++; end
    check($sformatf("latency[%0d]", w), 256'(c), 256'(exp_lat));
    repeat (hold) begin
      @(negedge clk);
      check($sformatf("hold_gnt[%0d]", w), 256'(gnt_v[w]), 256'(1));
    end
    @(posedge clk); #1 set_req(w, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check($sformatf("drop_gnt[%0d]", w),  256'(gnt_v[w]), 256'(0));
    check($sformatf("drop_busy[%0d]", w), 256'(busy_v[w]), 256'(0));
    fall_cyc = cyc;
  endtask

  initial begin
    int c;
    int last_fall;
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    wr_i = 1'b1; addr_i = 9'h005; wline_i = pat(32'h1000_0000);
    repeat (2) @(posedge clk);
    #1 req0 = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("reset_busy", 256'(busy0), 256'(0));
      check("reset_gnt", 256'(gnt0), 256'(0));
      check("reset_wrcnt", 256'(wrc0), 256'(0));
    end
    @(posedge clk); #1 req0 = 1'b0; rst = 1'b0;

    txn(0, 1'b1, 9'h005, pat(32'h1000_0000), 17, 0, 1'b0);
    check("wr_cnt_after_write", 256'(wrc0), 256'(1));

    txn(0, 1'b0, 9'h005, '0, 18, 5, 1'b0);
    for (int i = 0; i < 8; i++)
      check($sformatf("readback_w%0d", i), 256'(rdl0[32*i +: 32]), 256'(32'h1000_0000 + 32'(i)));
    check("rd_cnt_after_hold", 256'(rdc0), 256'(1));
    check("wr_cnt_after_hold", 256'(wrc0), 256'(1));

    txn(0, 1'b1, 9'h000, pat(32'h2000_0000), 17, 0, 1'b0);
    txn(0, 1'b0, 9'h000, '0, 18, 0, 1'b0);
    last_fall = fall_cyc;
    txn(0, 1'b1, 9'h001, pat(32'h3000_0000), 17, 0, 1'b1);
    check("b2b_gap", 256'(acc_cyc - last_fall), 256'(1));
    txn(0, 1'b0, 9'h000, '0, 18, 0, 1'b0);
    check("line0_w0", 256'(rdl0[31:0]), 256'(32'h2000_0000));
    check("line0_w7", 256'(rdl0[255:224]), 256'(32'h2000_0007));

    // Abort a write of line 0x7F while word 3 is being committed.
    txn(0, 1'b1, 9'h07F, pat(32'hA000_0000), 17, 0, 1'b0);
    @(posedge clk); #1;
    cur_wr[0] = 1'b1; cur_addr[0] = 9'h07F;
    wr_i = 1'b1; addr_i = 9'h07F; wline_i = pat(32'hB000_0000); req0 = 1'b1;
    c = 0;
    do begin @(negedge clk); c++; end while (!busy0 && c < 50);
    check("abort_accept", 256'(busy0), 256'(1));
    repeat (11) @(posedge clk);
    #1 rst = 1'b1; req0 = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) mem_model[0][{9'h07F, 3'(i)}] = 32'hB000_0000 + 32'(i);
    @(negedge clk);
    check("abort_busy", 256'(busy0), 256'(0));
    repeat (20) begin
      @(negedge clk);
      check("abort_no_gnt", 256'(gnt0), 256'(0));
    end
    txn(0, 1'b0, 9'h07F, '0, 18, 0, 1'b0);
    check("abort_w2_new", 256'(rdl0[95:64]), 256'(32'hB000_0002));
    check("abort_w3_old", 256'(rdl0[127:96]), 256'(32'hA000_0003));
    check("abort_w7_old", 256'(rdl0[255:224]), 256'(32'hA000_0007));
    check("abort_rd_cnt", 256'(rdc0), 256'(1));

    txn(1, 1'b1, 9'h000, pat(32'hC000_0000), 10, 0, 1'b0);
    txn(1, 1'b1, 9'h1FF, pat(32'hD000_0000), 10, 0, 1'b0);
    txn(1, 1'b0, 9'h1FF, '0, 11, 0, 1'b0);
    check("l1_top_w0", 256'(rdl1[31:0]), 256'(32'hD000_0000));
    check("l1_top_w7", 256'(rdl1[255:224]), 256'(32'hD000_0007));
    txn(1, 1'b0, 9'h000, '0, 11, 0, 1'b0);
    check("l1_line0_w0", 256'(rdl1[31:0]), 256'(32'hC000_0000));
    check("l1_rd_cnt", 256'(rdc1), 256'(2));
    check("l1_wr_cnt", 256'(wrc1), 256'(2));

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
